// File: rtl/prog_loader_pkg.sv
// Shared state encodings and line geometry for the UART program loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    LD_HDR,
    LD_LOAD,
    LD_PAD,
    LD_DONE
  } ld_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  localparam int unsigned WORDS_PER_LINE = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, framing check.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_ferr, w_ferr_nxt;
  logic        r_sync1, r_sync2, r_prev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = r_ferr;
    case (r_state)
      RX_IDLE: begin
        if (r_prev && !r_sync2) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        // A start that is high again at mid-bit was a glitch.
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
          else               w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          if (r_sync2) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = RX_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (r_sync2) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_byte_valid = r_valid;
  assign o_byte       = r_shift;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/prog_loader.sv
// UART program loader: header word count, then little-endian words written to
// dmem per word and to imem per 128-bit line, zero-padding the final line.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_LEN     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  output logic [ADDR_LEN-1:0] addr,
  output logic [127:0]        data,
  output logic                we_32,
  output logic                we_128,
  output logic                done,
  output logic                frame_err
);

  logic       w_byte_valid;
  logic [7:0] w_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rxd        (rxd),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (frame_err)
  );

  logic [1:0]  r_bcnt;
  logic [23:0] r_part;
  logic        w_word_done;
  logic [31:0] w_word;

  assign w_word_done = w_byte_valid && (r_bcnt == 2'd3);
  assign w_word      = {w_byte, r_part};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcnt <= '0;
      r_part <= '0;
    end else if (w_byte_valid) begin
      r_bcnt <= r_bcnt + 1'b1;
      case (r_bcnt)
        2'd0:    r_part[7:0]   <= w_byte;
        2'd1:    r_part[15:8]  <= w_byte;
        2'd2:    r_part[23:16] <= w_byte;
        default: r_part        <= r_part;
      endcase
    end
  end

  ld_state_t             r_state, w_state_nxt;
  logic [31:0]           r_rem, w_rem_nxt;
  logic [ADDR_LEN-3:0]   r_idx, w_idx_nxt;
  logic [ADDR_LEN-1:0]   r_addr, w_addr_nxt;
  logic [127:0]          r_data, w_data_nxt;
  logic                  r_we32, w_we32_nxt;
  logic                  r_we128, w_we128_nxt;
  logic                  r_done;
  logic                  w_line_end;

  assign w_line_end = (r_idx[1:0] == 2'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LD_HDR;
      r_rem   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we32  <= 1'b0;
      r_we128 <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_we32  <= w_we32_nxt;
      r_we128 <= w_we128_nxt;
      r_done  <= (r_state == LD_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_we32_nxt  = 1'b0;
    w_we128_nxt = 1'b0;
    case (r_state)
      LD_HDR: begin
        if (w_word_done) begin
          w_rem_nxt   = w_word;
          w_state_nxt = (w_word == 32'd0) ? LD_DONE : LD_LOAD;
        end
      end
      LD_LOAD: begin
        if (w_word_done) begin
          w_data_nxt  = {w_word, r_data[127:32]};
          w_addr_nxt  = {r_idx, 2'b00};
          w_idx_nxt   = r_idx + 1'b1;
          w_we32_nxt  = 1'b1;
          w_we128_nxt = w_line_end;
          w_rem_nxt   = r_rem - 32'd1;
          if (r_rem == 32'd1) w_state_nxt = w_line_end ? LD_DONE : LD_PAD;
        end
      end
      LD_PAD: begin
        w_data_nxt = {32'h0, r_data[127:32]};
        w_addr_nxt = {r_idx, 2'b00};
        w_idx_nxt  = r_idx + 1'b1;
        if (w_line_end) begin
          w_we128_nxt = 1'b1;
          w_state_nxt = LD_DONE;
        end
      end
      default: ;
    endcase
  end

  assign addr   = r_addr;
  assign data   = r_data;
  assign we_32  = r_we32;
  assign we_128 = r_we128;
  assign done   = r_done;

endmodule
